// File: rtl/wb_pkg.sv
// Shared types for the clocked writeback stage: op encoding, EX/WB payload and FSM states.
package wb_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int RIDW_DEF    = 4;
  localparam int SP_IDX_DEF  = 4;
  localparam int SP_STEP_DEF = 8;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ALU    = 4'd1,
    OP_LOAD   = 4'd2,
    OP_MULDIV = 4'd3,
    OP_PUSH   = 4'd4,
    OP_POP    = 4'd5,
    OP_CALL   = 4'd6,
    OP_RET    = 4'd7,
    OP_STORE  = 4'd8
  } wb_op_e;

  typedef struct packed {
    wb_op_e                op;
    logic [RIDW_DEF-1:0]   dst0;
    logic [RIDW_DEF-1:0]   dst1;
    logic [XLEN_DEF-1:0]   data0;
    logic [XLEN_DEF-1:0]   data1;
    logic                  sim_end;
  } ex_wb_t;

  typedef enum logic [1:0] {
    ST_ACCEPT     = 2'd0,
    ST_WAIT_STORE = 2'd1,
    ST_HALT       = 2'd2
  } wb_state_e;

  // Ops that leave a store in flight and must hold the stage until memory confirms it.
  function automatic logic needs_store_wait(input wb_op_e op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mod_wb_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set by issue, cleared by retirement.
// With WB_BYPASS_EN a register retiring this cycle reads as free unless issue re-reserves it.
module mod_wb_scoreboard #(
  parameter int NREGS = 16,
  localparam int RIDW = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_set,
  input  logic [RIDW-1:0] i_set_idx,
  input  logic            i_clr0,
  input  logic [RIDW-1:0] i_clr0_idx,
  input  logic            i_clr1,
  input  logic [RIDW-1:0] i_clr1_idx,
  input  logic [RIDW-1:0] i_look_a,
  input  logic [RIDW-1:0] i_look_b,
  output logic            o_busy_a,
  output logic            o_busy_b
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set)  w_set[i_set_idx]  = 1'b1;
    if (i_clr0) w_clr[i_clr0_idx] = 1'b1;
    if (i_clr1) w_clr[i_clr1_idx] = 1'b1;
  end

  // A set and a clear of the same register in one cycle leaves it reserved.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy <= '0;
    else         r_busy <= (r_busy & ~w_clr) | w_set;
  end

`ifdef WB_BYPASS_EN
  assign o_busy_a = r_busy[i_look_a] & ~(w_clr[i_look_a] & ~w_set[i_look_a]);
  assign o_busy_b = r_busy[i_look_b] & ~(w_clr[i_look_b] & ~w_set[i_look_b]);
`else
  assign o_busy_a = r_busy[i_look_a];
  assign o_busy_b = r_busy[i_look_b];
`endif

endmodule

// File: rtl/mod_wb_regfile.sv
// Clocked writeback stage with architectural register file, SP adjust, store wait and busy scoreboard.
// Define WB_BYPASS_EN to forward this cycle's writes onto the read ports.
module mod_wb_regfile
  import wb_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              NREGS    = 16,
  parameter int              SP_IDX   = SP_IDX_DEF,
  parameter int              SP_STEP  = SP_STEP_DEF,
  parameter logic [XLEN-1:0] SP_RESET = '0,
  parameter int              CNTW     = 32,
  localparam int             RIDW     = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic [3:0]      i_wb_op,
  input  logic [RIDW-1:0] i_wb_dst0,
  input  logic [RIDW-1:0] i_wb_dst1,
  input  logic [XLEN-1:0] i_wb_data0,
  input  logic [XLEN-1:0] i_wb_data1,
  input  logic            i_wb_sim_end,
  input  logic            i_store_done,
  input  logic            i_iss_set,
  input  logic [RIDW-1:0] i_iss_dst,
  input  logic [RIDW-1:0] i_rd_addr_a,
  input  logic [RIDW-1:0] i_rd_addr_b,
  output logic [XLEN-1:0] o_rd_data_a,
  output logic [XLEN-1:0] o_rd_data_b,
  output logic            o_rd_busy_a,
  output logic            o_rd_busy_b,
  output logic            o_store_wb_flag,
  output logic            o_sim_end,
  output logic [CNTW-1:0] o_retire_count
);

  localparam logic [RIDW-1:0] SP_ADDR = RIDW'(SP_IDX);
  localparam logic [XLEN-1:0] STEP    = XLEN'(SP_STEP);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] w_next [NREGS];
  wb_state_e       r_state;
  logic            r_pend_end;
  logic            r_store_flag;
  logic            r_sim_end;
  logic [CNTW-1:0] r_count;

  wb_op_e          w_op;
  logic            w_ready;
  logic            w_xfer;
  logic            w_we0;
  logic            w_we1;
  logic            w_sp_we;
  logic [XLEN-1:0] w_sp_val;

  assign w_op    = wb_op_e'(i_wb_op);
  assign w_ready = (r_state == ST_ACCEPT) && !i_reset;
  assign w_xfer  = i_wb_valid && w_ready;

  always_comb begin
    w_we0    = 1'b0;
    w_we1    = 1'b0;
    w_sp_we  = 1'b0;
    w_sp_val = r_regs[SP_ADDR];
    if (w_xfer) begin
      case (w_op)
        OP_ALU, OP_LOAD: w_we0 = 1'b1;
        OP_MULDIV: begin
          w_we0 = 1'b1;
          w_we1 = 1'b1;
        end
        OP_PUSH, OP_CALL: begin
          w_sp_we  = 1'b1;
          w_sp_val = r_regs[SP_ADDR] - STEP;
        end
        OP_RET: begin
          w_sp_we  = 1'b1;
          w_sp_val = r_regs[SP_ADDR] + STEP;
        end
        OP_POP: begin
          w_sp_we  = 1'b1;
          w_sp_val = r_regs[SP_ADDR] + STEP;
          w_we0    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Later assignments take priority: data0 beats the SP adjust, data1 beats data0.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_next[i] = r_regs[i];
      if (w_sp_we && (i == SP_IDX))               w_next[i] = w_sp_val;
      if (w_we0 && (i_wb_dst0 == RIDW'(i)))       w_next[i] = i_wb_data0;
      if (w_we1 && (i_wb_dst1 == RIDW'(i)))       w_next[i] = i_wb_data1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= w_next[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_ACCEPT;
      r_pend_end   <= 1'b0;
      r_store_flag <= 1'b0;
      r_sim_end    <= 1'b0;
      r_count      <= '0;
    end else begin
      r_store_flag <= 1'b0;
      case (r_state)
        ST_ACCEPT: begin
          if (w_xfer) begin
            r_count <= r_count + CNTW'(1);
            if (i_wb_sim_end) r_sim_end <= 1'b1;
            if (needs_store_wait(w_op)) begin
              r_state    <= ST_WAIT_STORE;
              r_pend_end <= i_wb_sim_end;
            end else if (i_wb_sim_end) begin
              r_state <= ST_HALT;
            end
          end
        end
        ST_WAIT_STORE: begin
          if (i_store_done) begin
            r_store_flag <= 1'b1;
            r_state      <= r_pend_end ? ST_HALT : ST_ACCEPT;
          end
        end
        ST_HALT: ;
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  mod_wb_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set      (i_iss_set),
    .i_set_idx  (i_iss_dst),
    .i_clr0     (w_we0),
    .i_clr0_idx (i_wb_dst0),
    .i_clr1     (w_we1),
    .i_clr1_idx (i_wb_dst1),
    .i_look_a   (i_rd_addr_a),
    .i_look_b   (i_rd_addr_b),
    .o_busy_a   (o_rd_busy_a),
    .o_busy_b   (o_rd_busy_b)
  );

`ifdef WB_BYPASS_EN
  assign o_rd_data_a = w_next[i_rd_addr_a];
  assign o_rd_data_b = w_next[i_rd_addr_b];
`else
  assign o_rd_data_a = r_regs[i_rd_addr_a];
  assign o_rd_data_b = r_regs[i_rd_addr_b];
`endif

  assign o_wb_ready      = w_ready;
  assign o_store_wb_flag = r_store_flag;
  assign o_sim_end       = r_sim_end;
  assign o_retire_count  = r_count;

endmodule
